// File: rtl/key_event_decoder.sv
// Turns debounced key flag/level pairs into click, double-click,
// long-press and auto-repeat pulses. The repeat event is on auto_repeat.
module key_event_decoder #(
  parameter logic [25:0] LONG_CNT = 26'd49_999_999,
  parameter logic [25:0] DCLK_CNT = 26'd14_999_999,
  parameter logic [25:0] REP_CNT  = 26'd9_999_999
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_flag,
  input  logic key_state,
  output logic click,
  output logic dclick,
  output logic long_press,
  output logic auto_repeat,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_LONG_HOLD,
    S_WAIT2,
    S_PRESS2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [25:0] cnt;
  logic [25:0] cnt_nxt;
  logic        click_nxt;
  logic        dclick_nxt;
  logic        long_nxt;
  logic        rep_nxt;
  logic        press;
  logic        rel;

  assign press = key_flag & ~key_state;
  assign rel   = key_flag &  key_state;

  // cnt_nxt defaults to 0, so every transition clears it
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = '0;
    click_nxt  = 1'b0;
    dclick_nxt = 1'b0;
    long_nxt   = 1'b0;
    rep_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (press)
          state_nxt = S_PRESS1;
      end
      S_PRESS1: begin
        if (rel) begin
          state_nxt = S_WAIT2;
        end else if (cnt == LONG_CNT) begin
          long_nxt  = 1'b1;
          state_nxt = S_LONG_HOLD;
        end else begin
          cnt_nxt = cnt + 26'd1;
        end
      end
      S_LONG_HOLD: begin
        if (rel)
          state_nxt = S_IDLE;
        else if (cnt == REP_CNT)
          rep_nxt = 1'b1;
        else
          cnt_nxt = cnt + 26'd1;
      end
      S_WAIT2: begin
        if (press) begin
          state_nxt = S_PRESS2;
        end else if (cnt == DCLK_CNT) begin
          click_nxt = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 26'd1;
        end
      end
      S_PRESS2: begin
        if (rel) begin
          dclick_nxt = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      click       <= 1'b0;
      dclick      <= 1'b0;
      long_press  <= 1'b0;
      auto_repeat <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      click       <= click_nxt;
      dclick      <= dclick_nxt;
      long_press  <= long_nxt;
      auto_repeat <= rep_nxt;
      busy        <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder: stimulus queues expected
// pulses, a monitor pops and checks them as the DUT emits them.
module tb_key_event_decoder;

  localparam int LONG = 99;
  localparam int DCLK = 29;
  localparam int REP  = 19;

  localparam int K_NONE  = 0;
  localparam int K_CLICK = 1;
  localparam int K_DCLK  = 2;
  localparam int K_LONG  = 3;
  localparam int K_REP   = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic key_flag;
  logic key_state;
  logic click;
  logic dclick;
  logic long_press;
  logic auto_repeat;
  logic busy;

  typedef struct {
    int kind;
    int edge_n;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  key_event_decoder #(
    .LONG_CNT(26'd99),
    .DCLK_CNT(26'd29),
    .REP_CNT (26'd19)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_flag   (key_flag),
    .key_state  (key_state),
    .click      (click),
    .dclick     (dclick),
    .long_press (long_press),
    .auto_repeat(auto_repeat),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act,
                     input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)",
               nm, act, req, cyc);
    end
  endtask

  // monitor: outputs are sampled 1 time unit after each edge
  int   m_n;
  int   m_k;
  exp_t m_e;
  always begin
    @(posedge clk);
    #1;
    if (click | dclick | long_press | auto_repeat) begin
      m_n = int'(click) + int'(dclick) + int'(long_press)
          + int'(auto_repeat);
      chk("onehot", m_n, 1);
      m_k = click ? K_CLICK : dclick ? K_DCLK :
            long_press ? K_LONG : K_REP;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected: got kind %0d at edge %0d, expected none",
                 m_k, cyc);
      end else begin
        m_e = q.pop_front();
        chk("kind", m_k, m_e.kind);
        chk("edge", cyc, m_e.edge_n);
      end
    end
  end

  // called at a negedge; the flag is sampled at edge cyc+1
  task automatic key_evt(input logic st, input int kind,
                         input int ofs, output int e);
    e = cyc + 1;
    if (kind != K_NONE)
      q.push_back('{kind: kind, edge_n: e + ofs});
    key_flag  = 1'b1;
    key_state = st;
    @(negedge clk);
    key_flag = 1'b0;
  endtask

  // next key_evt flag lands d cycles after the previous one
  task automatic gap(input int d);
    repeat (d - 1) @(negedge clk);
  endtask

  task automatic settle(input int n, input string nm);
    repeat (n) @(negedge clk);
    chk({nm, "_pending"}, q.size(), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    q.delete();
  endtask

  int e;

  initial begin
    rst_n     = 1'b0;
    key_flag  = 1'b0;
    key_state = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_click", int'(click), 0);
    chk("rst_dclick", int'(dclick), 0);
    chk("rst_long", int'(long_press), 0);
    chk("rst_rep", int'(auto_repeat), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // single click
    key_evt(1'b0, K_NONE, 0, e);
    chk("s1_busy", int'(busy), 1);
    gap(20);
    key_evt(1'b1, K_CLICK, DCLK + 1, e);
    settle(50, "s1");

    // double click
    key_evt(1'b0, K_NONE, 0, e);
    gap(20);
    key_evt(1'b1, K_NONE, 0, e);
    gap(10);
    key_evt(1'b0, K_NONE, 0, e);
    gap(15);
    key_evt(1'b1, K_DCLK, 0, e);
    settle(50, "s2");

    // long press, two repeats, release on third repeat count
    key_evt(1'b0, K_LONG, LONG + 1, e);
    q.push_back('{kind: K_REP, edge_n: e + LONG + 1 + REP + 1});
    q.push_back('{kind: K_REP, edge_n: e + LONG + 1 + 2 * (REP + 1)});
    gap(120);
    chk("s3_busy", int'(busy), 1);
    gap(40);
    key_evt(1'b1, K_NONE, 0, e);
    settle(50, "s3");

    // release on PRESS1 terminal count
    key_evt(1'b0, K_NONE, 0, e);
    gap(LONG + 1);
    key_evt(1'b1, K_CLICK, DCLK + 1, e);
    settle(50, "s4a");

    // second press on WAIT2 terminal count
    key_evt(1'b0, K_NONE, 0, e);
    gap(20);
    key_evt(1'b1, K_NONE, 0, e);
    gap(DCLK + 1);
    key_evt(1'b0, K_NONE, 0, e);
    gap(10);
    key_evt(1'b1, K_DCLK, 0, e);
    settle(50, "s4b");

    // reset while waiting for a second press
    key_evt(1'b0, K_NONE, 0, e);
    gap(20);
    key_evt(1'b1, K_NONE, 0, e);
    repeat (10) @(negedge clk);
    chk("s5_busy_pre", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("s5_busy_rst", int'(busy), 0);
    chk("s5_click_rst", int'(click), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    settle(60, "s5");

    // spurious release in IDLE, repeated press in PRESS1
    key_evt(1'b1, K_NONE, 0, e);
    repeat (5) @(negedge clk);
    chk("s6_idle_busy", int'(busy), 0);
    key_evt(1'b0, K_NONE, 0, e);
    gap(10);
    key_evt(1'b0, K_NONE, 0, e);
    chk("s6_busy", int'(busy), 1);
    gap(10);
    key_evt(1'b1, K_CLICK, DCLK + 1, e);
    settle(50, "s6");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
